error_inject_ctrl: RTL and testbench

// - Parametrised successor to the serial link error injector. Deserialises frames from a data/strobe link, XORs an error mask into selected frames, and re-serialises them.
// - Sits between sender and receiver on the link under test, for ECC/Hamming robustness tests.
// - Adds runtime modes (pass, always, one-shot, periodic), frame and error counters, and an optional pseudo-random mask.

---
 rtl/error_inject_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_error_inject_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/error_inject_ctrl.sv
// Serial-link error injector: deserialises WIDTH-bit frames from a data/strobe
// link, XORs a mode-selected error mask into chosen frames and re-serialises
// them one cycle after the last input bit. Keeps frame and error counters.
// Optional build macro ERRINJ_LFSR_EN gates the error mask with a
// pseudo-random WIDTH-bit Fibonacci LFSR that steps once per completed frame.
module error_inject_ctrl #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_in,
   input  logic             strobe_in,
   input  logic [1:WIDTH]   signal,
   input  logic [1:0]       mode,
   input  logic             arm,
   input  logic [CNT_W-1:0] period,
   output logic             data_out,
   output logic             strobe_out,
   output logic             armed,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   // Bit index runs 1..WIDTH; the same width also holds the TX bits-left count.
   localparam int unsigned IDX_W = $clog2(WIDTH + 1);

   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH);
   localparam logic [IDX_W-1:0] TX_REST   = IDX_W'(WIDTH - 1);

   localparam logic [1:0] MODE_PASS     = 2'b00;
   localparam logic [1:0] MODE_ALWAYS   = 2'b01;
   localparam logic [1:0] MODE_ONESHOT  = 2'b10;
   localparam logic [1:0] MODE_PERIODIC = 2'b11;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_t;

   // Receive side
   logic [IDX_W-1:0] bit_idx;
   logic [1:WIDTH]   rx_reg;
   logic [1:WIDTH]   rx_frame_c;
   logic             frame_done_c;

   // Injection decision
   logic [1:WIDTH]   mask_c;
   logic [1:WIDTH]   eff_mask_c;
   logic [1:WIDTH]   tx_frame_c;
   logic [CNT_W-1:0] pcnt;
   logic [CNT_W-1:0] pcnt_nxt;
   logic [CNT_W-1:0] period_m1_c;
   logic             armed_nxt;

   // Transmit side
   tx_state_t        state;
   tx_state_t        state_nxt;
   logic [1:WIDTH]   tx_reg;
   logic [1:WIDTH]   tx_reg_nxt;
   logic [IDX_W-1:0] tx_left;
   logic [IDX_W-1:0] tx_left_nxt;
   logic             data_out_nxt;
   logic             strobe_out_nxt;

   // Bits arrive in order, so a shift register places bit 1 at the MSB end.
   assign frame_done_c = strobe_in && (bit_idx == IDX_LAST);
   assign rx_frame_c   = (rx_reg << 1) | WIDTH'(data_in);

   // Receive shift register and bit position within the current frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_reg  <= '0;
         bit_idx <= IDX_FIRST;
      end else if (strobe_in) begin
         rx_reg  <= rx_frame_c;
         bit_idx <= frame_done_c ? IDX_FIRST : bit_idx + IDX_W'(1);
      end
   end

   // Period of zero is treated as one, i.e. inject on every frame.
   assign period_m1_c = (period == '0) ? '0 : period - CNT_W'(1);

   // Mode decision: mask for the completing frame, next pcnt and armed state
   always_comb begin
      mask_c    = '0;
      pcnt_nxt  = '0;
      armed_nxt = armed;
      case (mode)
         MODE_PASS: begin
            mask_c = '0;
         end
         MODE_ALWAYS: begin
            mask_c = signal;
         end
         MODE_ONESHOT: begin
            if (armed) begin
               mask_c = signal;
               if (frame_done_c) begin
                  armed_nxt = 1'b0;
               end
            end else if (arm) begin
               armed_nxt = 1'b1;
            end
         end
         MODE_PERIODIC: begin
            // >= rather than == so a shrunken period cannot strand pcnt above it
            if (pcnt >= period_m1_c) begin
               mask_c = signal;
            end else begin
               pcnt_nxt = pcnt + CNT_W'(1);
            end
         end
      endcase
   end

`ifdef ERRINJ_LFSR_EN
   // Maximal-length tap sets for common widths; other widths fall back to the top two bits.
   function automatic logic [31:0] lfsr_taps(input int unsigned w);
      case (w)
         2:       lfsr_taps = 32'h0000_0003;
         3:       lfsr_taps = 32'h0000_0006;
         4:       lfsr_taps = 32'h0000_000C;
         5:       lfsr_taps = 32'h0000_0014;
         6:       lfsr_taps = 32'h0000_0030;
         7:       lfsr_taps = 32'h0000_0060;
         8:       lfsr_taps = 32'h0000_00B8;
         9:       lfsr_taps = 32'h0000_0110;
         10:      lfsr_taps = 32'h0000_0240;
         11:      lfsr_taps = 32'h0000_0500;
         12:      lfsr_taps = 32'h0000_0E08;
         13:      lfsr_taps = 32'h0000_1C80;
         14:      lfsr_taps = 32'h0000_3802;
         15:      lfsr_taps = 32'h0000_6000;
         16:      lfsr_taps = 32'h0000_D008;
         default: lfsr_taps = 32'h0000_0003 << (w - 2);
      endcase
   endfunction

   localparam logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(lfsr_taps(WIDTH));

   logic [WIDTH-1:0] lfsr;

   // Pseudo-random mask source, stepped once per completed input frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= '1;
      end else if (frame_done_c) begin
         lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
      end
   end

   assign eff_mask_c = mask_c & lfsr;
`else
   assign eff_mask_c = mask_c;
`endif

   assign tx_frame_c = rx_frame_c ^ eff_mask_c;

   // Counters, periodic phase and one-shot arm flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
         pcnt      <= '0;
         armed     <= 1'b0;
      end else begin
         armed <= armed_nxt;
         if (frame_done_c) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            pcnt      <= pcnt_nxt;
            if ((eff_mask_c != '0) && (err_cnt != '1)) begin
               err_cnt <= err_cnt + CNT_W'(1);
            end
         end
      end
   end

   // TX state register and registered serial outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= TX_IDLE;
         tx_reg     <= '0;
         tx_left    <= '0;
         data_out   <= 1'b0;
         strobe_out <= 1'b0;
      end else begin
         state      <= state_nxt;
         tx_reg     <= tx_reg_nxt;
         tx_left    <= tx_left_nxt;
         data_out   <= data_out_nxt;
         strobe_out <= strobe_out_nxt;
      end
   end

   // TX next state: load on completion (bit 1 goes out next cycle), then shift out the rest
   always_comb begin
      state_nxt      = state;
      tx_reg_nxt     = tx_reg;
      tx_left_nxt    = tx_left;
      data_out_nxt   = 1'b0;
      strobe_out_nxt = 1'b0;
      if (frame_done_c) begin
         data_out_nxt   = tx_frame_c[1];
         strobe_out_nxt = 1'b1;
         tx_reg_nxt     = tx_frame_c << 1;
         tx_left_nxt    = TX_REST;
         state_nxt      = TX_SEND;
      end else begin
         case (state)
            TX_IDLE: begin
               state_nxt = TX_IDLE;
            end
            TX_SEND: begin
               if (tx_left != '0) begin
                  data_out_nxt   = tx_reg[1];
                  strobe_out_nxt = 1'b1;
                  tx_reg_nxt     = tx_reg << 1;
                  tx_left_nxt    = tx_left - IDX_W'(1);
               end else begin
                  state_nxt = TX_IDLE;
               end
            end
            default: begin
               state_nxt = TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_error_inject_ctrl.sv
// Self-checking bench for error_inject_ctrl: table vectors, hand-written
// corner sequences and a randomized run against a frame-level reference model.
module tb_error_inject_ctrl;

   localparam int unsigned W   = 7;
   localparam int unsigned CW  = 16;
   localparam int unsigned CW4 = 4;

   typedef logic [1:W] frame_t;

   typedef struct {
      logic [1:0] mode;
      frame_t     sig;
      frame_t     din;
      frame_t     dout;
      int         err;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           data_in;
   logic           strobe_in;
   frame_t         signal;
   logic [1:0]     mode;
   logic           arm;
   logic [CW-1:0]  period;
   logic           data_out;
   logic           strobe_out;
   logic           armed;
   logic [CW-1:0]  frame_cnt;
   logic [CW-1:0]  err_cnt;
   logic           data_out4;
   logic           strobe_out4;
   logic           armed4;
   logic [CW4-1:0] frame_cnt4;
   logic [CW4-1:0] err_cnt4;

   error_inject_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .strobe_in(strobe_in),
      .signal(signal), .mode(mode), .arm(arm), .period(period),
      .data_out(data_out), .strobe_out(strobe_out), .armed(armed),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   error_inject_ctrl #(.WIDTH(W), .CNT_W(CW4)) dut4 (
      .clk(clk), .rst(rst), .data_in(data_in), .strobe_in(strobe_in),
      .signal(signal), .mode(mode), .arm(arm), .period(period[CW4-1:0]),
      .data_out(data_out4), .strobe_out(strobe_out4), .armed(armed4),
      .frame_cnt(frame_cnt4), .err_cnt(err_cnt4)
   );

   always #5 clk = ~clk;

   int     tests = 0;
   int     fails = 0;
   frame_t out_q[$];
   frame_t exp_q[$];
   frame_t col;
   int     col_n   = 0;
   int     gap_err = 0;

   // Reference model state
   bit m_armed;
   int m_since;
   int m_frames;
   int m_errs;

   // Collect output frames; a strobe gap inside a frame is an error
   always @(negedge clk) begin
      if (rst) begin
         col_n = 0;
      end else if (strobe_out) begin
         col   = {col[2:W], data_out};
         col_n = col_n + 1;
         if (col_n == int'(W)) begin
            out_q.push_back(col);
            col_n = 0;
         end
      end else if (col_n != 0) begin
         gap_err = gap_err + 1;
         col_n   = 0;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_armed  = 1'b0;
      m_since  = 0;
      m_frames = 0;
      m_errs   = 0;
   endtask

   // Frame-level rules: decide mask from mode/armed/period, update counters
   task automatic model_frame(input frame_t f, input bit arm_last);
      frame_t m;
      int     eff;
      bit     old;
      m   = '0;
      old = m_armed;
      case (mode)
         2'd1: m = signal;
         2'd2: if (old) m = signal;
         2'd3: begin
            eff = (period == 0) ? 1 : int'(period);
            m_since++;
            if (m_since >= eff) begin
               m       = signal;
               m_since = 0;
            end
         end
         default: m = '0;
      endcase
      if (mode != 2'd3) m_since = 0;
      if (mode == 2'd2 && old) m_armed = 1'b0;
      if (mode == 2'd2 && !old && arm_last) m_armed = 1'b1;
      m_frames = (m_frames + 1) % 65536;
      if (m != '0 && m_errs < 65535) m_errs++;
      exp_q.push_back(f ^ m);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      strobe_in = 1'b0;
      data_in   = 1'b0;
      arm       = 1'b0;
      step();
      step();
      rst = 1'b0;
      model_reset();
      out_q.delete();
      exp_q.delete();
   endtask

   // Send one frame, bit 1 first, with up to max_gap idle cycles before each bit
   task automatic send_frame(input frame_t f, input int max_gap, input bit arm_last);
      int g;
      for (int i = 1; i <= int'(W); i++) begin
         if (max_gap > 0) begin
            g = int'($urandom_range(max_gap, 0));
            repeat (g) begin
               strobe_in = 1'b0;
               data_in   = 1'($urandom);
               step();
            end
         end
         strobe_in = 1'b1;
         data_in   = f[i];
         arm       = (i == int'(W)) && arm_last;
         step();
      end
      strobe_in = 1'b0;
      data_in   = 1'b0;
      arm       = 1'b0;
      model_frame(f, arm_last);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
      if (mode == 2'd2 && !m_armed) m_armed = 1'b1;
   endtask

   task automatic expect_frame(input string name, input frame_t exp);
      int t;
      t = 0;
      while (out_q.size() == 0 && t < int'(4 * W)) begin
         step();
         t++;
      end
      if (out_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: no output frame within %0d cycles, expected %b", name, 4 * W, exp);
      end else begin
         check(name, out_q.pop_front(), exp);
      end
   endtask

   // Compare against a hand-derived constant; the model's entry is dropped
   task automatic hand_frame(input string name, input frame_t exp);
      frame_t tmp;
      expect_frame(name, exp);
      if (exp_q.size() > 0) tmp = exp_q.pop_front();
   endtask

   task automatic drain_compare(input string name);
      frame_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         expect_frame(name, e);
      end
      repeat (2 * W) step();
      check({name, "_extra"}, out_q.size(), 0);
   endtask

   vec_t   tbl[8];
   frame_t f_base;
   frame_t f_flip;
   frame_t sig_b2;
   frame_t d;

   initial begin
      rst       = 1'b1;
      data_in   = 1'b0;
      strobe_in = 1'b0;
      signal    = '0;
      mode      = 2'b00;
      arm       = 1'b0;
      period    = '0;
      f_base    = 7'b1011001;
      f_flip    = 7'b1011101;
      sig_b2    = 7'b0000100;

      tbl[0] = '{2'b00, 7'b0000100, 7'b1011001, 7'b1011001, 0};
      tbl[1] = '{2'b01, 7'b0000100, 7'b1011001, 7'b1011101, 1};
      tbl[2] = '{2'b01, 7'b0000100, 7'b1011001, 7'b1011101, 2};
      tbl[3] = '{2'b01, 7'b0000100, 7'b1011001, 7'b1011101, 3};
      tbl[4] = '{2'b01, 7'b1111111, 7'b0000000, 7'b1111111, 4};
      tbl[5] = '{2'b01, 7'b0000000, 7'b1010101, 7'b1010101, 4};
      tbl[6] = '{2'b00, 7'b1111111, 7'b1100110, 7'b1100110, 4};
      tbl[7] = '{2'b01, 7'b1000001, 7'b1000001, 7'b0000000, 5};

      // Reset state
      step();
      check("rst_strobe_out", strobe_out, 0);
      check("rst_data_out", data_out, 0);
      do_reset();
      check("rst_armed", armed, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);

      // Table vectors: pass and always modes, latency of the first output bit
      for (int i = 0; i < 8; i++) begin
         mode   = tbl[i].mode;
         signal = tbl[i].sig;
         d      = tbl[i].dout;
         send_frame(tbl[i].din, 1, 1'b0);
         check($sformatf("tbl%0d_lat_strobe", i), strobe_out, 1);
         check($sformatf("tbl%0d_lat_bit1", i), data_out, d[1]);
         check($sformatf("tbl%0d_frame_cnt", i), frame_cnt, i + 1);
         check($sformatf("tbl%0d_err_cnt", i), err_cnt, tbl[i].err);
         hand_frame($sformatf("tbl%0d_frame", i), d);
      end

      // One-shot: arm then two frames
      mode   = 2'b10;
      signal = sig_b2;
      check("os_armed0", armed, 0);
      pulse_arm();
      check("os_armed1", armed, 1);
      send_frame(f_base, 0, 1'b0);
      check("os_armed_clr", armed, 0);
      hand_frame("os_first", f_flip);
      send_frame(f_base, 0, 1'b0);
      hand_frame("os_second", f_base);
      // Arm on the completion edge: that frame clean, the next flipped
      send_frame(f_base, 0, 1'b1);
      check("os_same_edge_armed", armed, 1);
      hand_frame("os_same_edge_clean", f_base);
      send_frame(f_base, 0, 1'b0);
      hand_frame("os_same_edge_next", f_flip);
      check("os_same_edge_clr", armed, 0);
      // Arm ignored outside one-shot mode
      mode = 2'b01;
      signal = '0;
      pulse_arm();
      check("os_arm_ignored", armed, 0);
      // Armed persists across a mode change
      mode   = 2'b10;
      signal = sig_b2;
      pulse_arm();
      pulse_arm();
      mode = 2'b00;
      send_frame(f_base, 0, 1'b0);
      hand_frame("os_persist_clean", f_base);
      check("os_persist_armed", armed, 1);
      mode = 2'b10;
      send_frame(f_base, 0, 1'b0);
      hand_frame("os_persist_flip", f_flip);
      check("os_persist_clr", armed, 0);
      check("os_frame_cnt", frame_cnt, m_frames);
      check("os_err_cnt", err_cnt, m_errs);

      // Periodic: period 3 flips frames 3, 6, 9; period 0 flips every frame
      mode   = 2'b11;
      period = 16'd3;
      for (int k = 1; k <= 9; k++) begin
         send_frame(f_base, 1, 1'b0);
         hand_frame($sformatf("per3_f%0d", k), (k % 3 == 0) ? f_flip : f_base);
      end
      check("per3_err_cnt", err_cnt, m_errs);
      period = 16'd0;
      for (int k = 1; k <= 3; k++) begin
         send_frame(f_base, 0, 1'b0);
         hand_frame($sformatf("per0_f%0d", k), f_flip);
      end
      check("per0_err_cnt", err_cnt, m_errs);
      check("per_frame_cnt", frame_cnt, m_frames);

      // Reset mid-RX after bit 4, with a one-shot pending
      mode = 2'b10;
      pulse_arm();
      mode   = 2'b01;
      signal = sig_b2;
      for (int i = 1; i <= 4; i++) begin
         strobe_in = 1'b1;
         data_in   = f_base[i];
         step();
      end
      strobe_in = 1'b0;
      rst = 1'b1;
      #1;
      check("rxrst_strobe_out", strobe_out, 0);
      check("rxrst_armed", armed, 0);
      check("rxrst_frame_cnt", frame_cnt, 0);
      check("rxrst_err_cnt", err_cnt, 0);
      step();
      step();
      rst = 1'b0;
      model_reset();
      out_q.delete();
      exp_q.delete();
      send_frame(f_base, 0, 1'b0);
      check("rxrst_next_cnt", frame_cnt, 1);
      hand_frame("rxrst_next_frame", f_flip);

      // Reset mid-TX while bit 2 is on the line
      mode = 2'b00;
      d    = 7'b1111111;
      send_frame(d, 0, 1'b0);
      step();
      check("txrst_pre_strobe", strobe_out, 1);
      check("txrst_pre_data", data_out, 1);
      rst = 1'b1;
      #1;
      check("txrst_strobe_out", strobe_out, 0);
      check("txrst_data_out", data_out, 0);
      step();
      step();
      rst = 1'b0;
      model_reset();
      out_q.delete();
      exp_q.delete();
      d = 7'b1100101;
      send_frame(d, 0, 1'b0);
      check("txrst_next_cnt", frame_cnt, 1);
      hand_frame("txrst_next_frame", d);

      // Saturation with a 4-bit counter instance, 20 back-to-back frames
      do_reset();
      mode   = 2'b01;
      signal = 7'b1111111;
      for (int k = 0; k < 20; k++) send_frame(W'($urandom), 0, 1'b0);
      drain_compare("sat_frame");
      check("sat4_frame_cnt", frame_cnt4, 4);
      check("sat4_err_cnt", err_cnt4, 15);
      check("sat16_frame_cnt", frame_cnt, 20);
      check("sat16_err_cnt", err_cnt, 20);
      check("sat_idle_strobe", strobe_out4, 0);

      // Randomized run against the reference model
      do_reset();
      period = CW'($urandom_range(4, 0));
      for (int k = 0; k < 60; k++) begin
         mode   = 2'($urandom);
         signal = W'($urandom);
         if ($urandom_range(3, 0) == 0) pulse_arm();
         send_frame(W'($urandom), 2, ($urandom_range(3, 0) == 0));
      end
      drain_compare("rnd_frame");
      check("rnd_frame_cnt", frame_cnt, m_frames);
      check("rnd_err_cnt", err_cnt, m_errs);
      check("rnd_armed", armed, m_armed);

      check("strobe_contiguous", gap_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
